// File: rtl/reconfig_ctrl_16bit_if.sv
// Bundle between the dual-rail datapath monitor and its sequencing controller.
// The master drives the rails and controls; the slave reports status.
interface reconfig_ctrl_16bit_if #(
    parameter int TRANS_W = 8
);
    logic               monitor_en;
    logic               clear;
    logic [15:0]        x0;
    logic [15:0]        y0;
    logic [15:0]        x1;
    logic [15:0]        y1;
    logic               logic_en;
    logic [15:0]        fault_map;
    logic [4:0]         fault_cnt;
    logic [TRANS_W-1:0] trans_cnt;
    logic               fatal;
    logic [2:0]         state;

    modport master (
        output monitor_en,
        output clear,
        output x0,
        output y0,
        output x1,
        output y1,
        input  logic_en,
        input  fault_map,
        input  fault_cnt,
        input  trans_cnt,
        input  fatal,
        input  state
    );

    modport slave (
        input  monitor_en,
        input  clear,
        input  x0,
        input  y0,
        input  x1,
        input  y1,
        output logic_en,
        output fault_map,
        output fault_cnt,
        output trans_cnt,
        output fatal,
        output state
    );
endinterface

// File: rtl/reconfig_ctrl_16bit.sv
// Sequencing controller for the 16-bit dual-rail reconfiguration datapath:
// filters transient rail disagreements, confirms faults, escalates to fatal.
module reconfig_ctrl_16bit #(
    parameter int CONFIRM_CYCLES = 4,
    parameter int TRANS_W        = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    reconfig_ctrl_16bit_if.slave  bus
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] MONITOR  = 3'd1;
    localparam logic [2:0] CONFIRM  = 3'd2;
    localparam logic [2:0] RECONFIG = 3'd3;
    localparam logic [2:0] FAIL     = 3'd4;

    localparam logic [3:0] N = 4'(CONFIRM_CYCLES);
    localparam logic [TRANS_W-1:0] TRANS_ONE = {{(TRANS_W-1){1'b0}}, 1'b1};

    logic [2:0]         state_q;
    logic [2:0]         state_n;
    logic [3:0]         cnt_q;
    logic [3:0]         cnt_n;
    logic [3:0]         cnt_inc;
    logic [15:0]        cand_q;
    logic [15:0]        cand_n;
    logic [15:0]        map_q;
    logic [15:0]        map_n;
    logic [TRANS_W-1:0] trans_q;
    logic [TRANS_W-1:0] trans_n;
    logic               fatal_q;
    logic               fatal_n;

    logic [15:0] err;
    logic [15:0] unrec;
    logic        any_err;
    logic        any_unrec;
    logic [4:0]  pop;

    // A bit is suspect if either pair loses complementarity or the pairs
    // disagree; it is unrecoverable only when both pairs are broken.
    assign err = ~(bus.x0 ^ bus.y0) | ~(bus.x1 ^ bus.y1)
               | (bus.x0 ^ bus.x1) | (bus.y0 ^ bus.y1);
    assign unrec = ~(bus.x0 ^ bus.y0) & ~(bus.x1 ^ bus.y1);
    assign any_err   = |err;
    assign any_unrec = |unrec;
    assign cnt_inc   = cnt_q + 4'd1;

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        cand_n  = cand_q;
        map_n   = map_q;
        trans_n = trans_q;
        fatal_n = fatal_q;
        if (bus.clear) begin
            state_n = bus.monitor_en ? MONITOR : IDLE;
            cnt_n   = '0;
            cand_n  = '0;
            map_n   = '0;
            trans_n = '0;
            fatal_n = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.monitor_en) begin
                        state_n = MONITOR;
                    end
                end
                MONITOR: begin
                    if (any_err) begin
                        cand_n = err;
                        if (N == 4'd1) begin
                            // Single-sample confirm: record now, counter
                            // restarts for unrecoverable tracking.
                            map_n   = map_q | err;
                            cnt_n   = '0;
                            state_n = RECONFIG;
                        end else begin
                            cnt_n   = 4'd1;
                            state_n = CONFIRM;
                        end
                    end else if (!bus.monitor_en) begin
                        state_n = IDLE;
                    end
                end
                CONFIRM: begin
                    if (any_err) begin
                        cand_n = cand_q | err;
                        if (cnt_inc == N) begin
                            map_n   = map_q | cand_q | err;
                            cnt_n   = '0;
                            state_n = RECONFIG;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else begin
                        if (trans_q != '1) begin
                            trans_n = trans_q + TRANS_ONE;
                        end
                        cand_n  = '0;
                        cnt_n   = '0;
                        state_n = MONITOR;
                    end
                end
                RECONFIG: begin
                    map_n = map_q | err;
                    if (any_unrec) begin
                        if (cnt_inc == N) begin
                            fatal_n = 1'b1;
                            state_n = FAIL;
                        end
                        cnt_n = cnt_inc;
                    end else begin
                        cnt_n = '0;
                    end
                end
                FAIL: begin
                    map_n   = map_q | err;
                    fatal_n = 1'b1;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
            map_q   <= '0;
            trans_q <= '0;
            fatal_q <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            cand_q  <= cand_n;
            map_q   <= map_n;
            trans_q <= trans_n;
            fatal_q <= fatal_n;
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < 16; i++) begin
            pop = pop + {4'd0, map_q[i]};
        end
    end

    assign bus.logic_en  = (state_q == RECONFIG) || (state_q == FAIL);
    assign bus.fault_map = map_q;
    assign bus.fault_cnt = pop;
    assign bus.trans_cnt = trans_q;
    assign bus.fatal     = fatal_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_reconfig_ctrl_16bit.sv
// Directed scoreboard bench for reconfig_ctrl_16bit with CONFIRM_CYCLES=4.
module tb_reconfig_ctrl_16bit;

    localparam logic [15:0] HX = 16'hA5A5;
    localparam logic [15:0] HY = 16'h5A5A;

    typedef struct {
        logic [2:0]  st;
        logic        le;
        logic [15:0] fm;
        logic [4:0]  fc;
        logic [7:0]  tc;
        logic        ft;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t  q[$];
    string tq[$];

    reconfig_ctrl_16bit_if #(.TRANS_W(8)) bus ();

    reconfig_ctrl_16bit #(
        .CONFIRM_CYCLES(4),
        .TRANS_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic men, input logic clr,
                         input logic [15:0] a0, input logic [15:0] b0,
                         input logic [15:0] a1, input logic [15:0] b1);
        bus.monitor_en = men;
        bus.clear      = clr;
        bus.x0 = a0;
        bus.y0 = b0;
        bus.x1 = a1;
        bus.y1 = b1;
    endtask

    task automatic push(input string tag, input logic [2:0] st,
                        input logic le, input logic [15:0] fm,
                        input logic [4:0] fc, input logic [7:0] tc,
                        input logic ft);
        exp_t e;
        e.st = st; e.le = le; e.fm = fm;
        e.fc = fc; e.tc = tc; e.ft = ft;
        q.push_back(e);
        tq.push_back(tag);
    endtask

    task automatic cmp(input string tag, input string f,
                       input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, f, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (q.size() != 0) begin
            exp_t  e;
            string t;
            e = q.pop_front();
            t = tq.pop_front();
            cmp(t, "state", {13'd0, bus.state}, {13'd0, e.st});
            cmp(t, "logic_en", {15'd0, bus.logic_en}, {15'd0, e.le});
            cmp(t, "fault_map", bus.fault_map, e.fm);
            cmp(t, "fault_cnt", {11'd0, bus.fault_cnt}, {11'd0, e.fc});
            cmp(t, "trans_cnt", {8'd0, bus.trans_cnt}, {8'd0, e.tc});
            cmp(t, "fatal", {15'd0, bus.fatal}, {15'd0, e.ft});
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, HX, HY, HX, HY);
        rst = 1'b1;
        push("reset", 3'd0, 0, 16'h0, 5'd0, 8'd0, 0);
        tick();
        rst = 1'b0;

        drive(1'b1, 1'b0, HX, HY, HX, HY);
        for (int i = 0; i < 49; i++) tick();
        push("healthy", 3'd1, 0, 16'h0, 5'd0, 8'd0, 0);
        tick();

        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, 1'b0, HX, HY, HX ^ 16'h0080, HY);
            if (k == 1) push("burst_start", 3'd2, 0, 16'h0, 5'd0, 8'd0, 0);
            tick();
            tick();
            drive(1'b1, 1'b0, HX, HY, HX, HY);
            push($sformatf("burst%0d", k), 3'd1, 0, 16'h0, 5'd0, 8'(k), 0);
            tick();
        end

        drive(1'b1, 1'b0, 16'hA5A4, HY, HX, HY);
        tick();
        tick();
        push("confirm3", 3'd2, 0, 16'h0, 5'd0, 8'd3, 0);
        tick();
        push("confirm4", 3'd3, 1, 16'h0001, 5'd1, 8'd3, 0);
        tick();

        drive(1'b0, 1'b0, HX, HY, HX, HY);
        push("reconfig_hold", 3'd3, 1, 16'h0001, 5'd1, 8'd3, 0);
        tick();
        drive(1'b0, 1'b0, HX, 16'h5A52, HX, 16'h5A52);
        tick();
        tick();
        push("unrec3", 3'd3, 1, 16'h0009, 5'd2, 8'd3, 0);
        tick();
        push("unrec4", 3'd4, 1, 16'h0009, 5'd2, 8'd3, 1);
        tick();
        push("fail_hold", 3'd4, 1, 16'h0009, 5'd2, 8'd3, 1);
        tick();

        drive(1'b1, 1'b1, HX, HY, HX, HY);
        push("clear_fail", 3'd1, 0, 16'h0, 5'd0, 8'd0, 0);
        tick();

        drive(1'b1, 1'b0, 16'hA5A4, HY, HX, HY);
        tick();
        push("pre_rst", 3'd2, 0, 16'h0, 5'd0, 8'd0, 0);
        tick();
        rst = 1'b1;
        push("rst_confirm", 3'd0, 0, 16'h0, 5'd0, 8'd0, 0);
        tick();
        rst = 1'b0;
        drive(1'b1, 1'b0, HX, HY, HX, HY);
        tick();

        drive(1'b1, 1'b0, 16'hA5A4, HY, HX, HY);
        tick();
        tick();
        push("pre_clear", 3'd2, 0, 16'h0, 5'd0, 8'd0, 0);
        tick();
        drive(1'b1, 1'b1, 16'hA5A4, HY, HX, HY);
        push("clear_wins", 3'd1, 0, 16'h0, 5'd0, 8'd0, 0);
        tick();

        drive(1'b0, 1'b0, HX, HY, HX, HY);
        push("park_idle", 3'd0, 0, 16'h0, 5'd0, 8'd0, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
